// File: rtl/bufferdomain_fifo.sv
// Strobe-capture FIFO: synchronises an asynchronous capture strobe, queues input_data on each rise,
// and drains through a valid/ready handshake or as one-cycle auto-drain pulses.
module bufferdomain_fifo #(
  parameter int unsigned DW          = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_MODE  = 0,
  parameter int unsigned DROP_W      = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DW-1:0]            input_data,
  input  logic                     input_enable,
  output logic [DW-1:0]            output_data,
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     overflow_clear,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [PW-1:0]          wr_q, wr_d;
  logic [PW-1:0]          rd_q, rd_d;
  logic [PW-1:0]          level_q, level_d;
  logic                   valid_q, valid_d;
  logic [DW-1:0]          data_q, data_d;
  logic                   ovf_q, ovf_d;
  logic [DROP_W-1:0]      drop_q, drop_d;
  logic                   rise_c, full_c, pop_c, push_c, drop_c, nonempty_c;
  logic [DW-1:0]          mem_q [DEPTH];

  // Next-state logic; output_data is a registered look-ahead of the head after this edge.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], input_enable};
    hist_d     = sync_q[SYNC_STAGES-1];
    rise_c     = sync_q[SYNC_STAGES-1] & ~hist_q;
    full_c     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop_c      = valid_q & ((PULSE_MODE != 0) | output_ready);
    push_c     = rise_c & (~full_c | pop_c);
    drop_c     = rise_c & full_c & ~pop_c;
    wr_d       = wr_q + PW'(push_c);
    rd_d       = rd_q + PW'(pop_c);
    level_d    = wr_d - rd_d;
    nonempty_c = (wr_d != rd_d);
    valid_d    = nonempty_c & ((PULSE_MODE == 0) | ~valid_q);
    data_d     = data_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;

    // A word written this edge into the slot that becomes head must be forwarded from the input.
    if (nonempty_c) begin
      if (push_c && (rd_d[AW-1:0] == wr_q[AW-1:0])) begin
        data_d = input_data;
      end else begin
        data_d = mem_q[rd_d[AW-1:0]];
      end
    end

    if (overflow_clear) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    // A drop in the same cycle as a clear wins and restarts the count at one.
    if (drop_c) begin
      ovf_d = 1'b1;
      if (overflow_clear) begin
        drop_d = DROP_W'(1);
      end else if (!(&drop_q)) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem_q[wr_q[AW-1:0]] <= input_data;
    end
  end

  assign output_data  = data_q;
  assign output_valid = valid_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_bufferdomain_fifo.sv
// Self-checking bench for bufferdomain_fifo: handshake, pulse-drain and narrow drop-counter variants
// driven from shared inputs and checked against a queue-based reference model.
module tb_bufferdomain_fifo;

  localparam int SYNC  = 2;
  localparam int DEPTH = 4;

  logic       clock, reset;
  logic [7:0] input_data;
  logic       input_enable, output_ready, overflow_clear;

  logic [7:0] o0_data, p_data, s_data;
  logic       o0_valid, p_valid, s_valid;
  logic [2:0] o0_level, p_level, s_level;
  logic       o0_ovf, p_ovf, s_ovf;
  logic [7:0] o0_drop, p_drop;
  logic [1:0] s_drop;

  int tests_run;
  int tests_failed;
  logic [7:0] got[$];

  bufferdomain_fifo dut0 (
    .clock(clock), .reset(reset), .input_data(input_data), .input_enable(input_enable),
    .output_data(o0_data), .output_valid(o0_valid), .output_ready(output_ready),
    .level(o0_level), .overflow(o0_ovf), .overflow_clear(overflow_clear), .drop_count(o0_drop));

  bufferdomain_fifo #(.PULSE_MODE(1)) dutp (
    .clock(clock), .reset(reset), .input_data(input_data), .input_enable(input_enable),
    .output_data(p_data), .output_valid(p_valid), .output_ready(output_ready),
    .level(p_level), .overflow(p_ovf), .overflow_clear(overflow_clear), .drop_count(p_drop));

  bufferdomain_fifo #(.DROP_W(2)) duts (
    .clock(clock), .reset(reset), .input_data(input_data), .input_enable(input_enable),
    .output_data(s_data), .output_valid(s_valid), .output_ready(output_ready),
    .level(s_level), .overflow(s_ovf), .overflow_clear(overflow_clear), .drop_count(s_drop));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; input_enable = 1'b0; output_ready = 1'b0; overflow_clear = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // One capture: strobe high 4 clocks with data held, then low 2 clocks.
  task automatic strobe(input logic [7:0] d);
    input_data = d;
    input_enable = 1'b1;
    repeat (4) @(negedge clock);
    input_enable = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Records words popped through the handshake (which: 0 = dut0, 2 = duts).
  task automatic collect(input int which, input int n);
    got.delete();
    for (int c = 0; c < 200 && got.size() < n; c++) begin
      if (which == 0 && o0_valid && output_ready) got.push_back(o0_data);
      if (which == 2 && s_valid && output_ready) got.push_back(s_data);
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    do_reset();
    strobe(8'h3C);
    tests_run++; if (o0_level !== 3'd1) begin tests_failed++; $display("FAIL reset_pre_level act=%0d exp=1", o0_level); end
    reset = 1'b1;
    #1;
    tests_run++; if (o0_level !== 3'd0) begin tests_failed++; $display("FAIL reset_level act=%0d exp=0", o0_level); end
    tests_run++; if (o0_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid act=%b exp=0", o0_valid); end
    tests_run++; if (o0_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data act=%h exp=00", o0_data); end
    tests_run++; if (o0_ovf !== 1'b0 || o0_drop !== 8'd0) begin tests_failed++; $display("FAIL reset_ovf act=%b/%0d exp=0/0", o0_ovf, o0_drop); end
    tests_run++; if (p_valid !== 1'b0 || p_level !== 3'd0) begin tests_failed++; $display("FAIL reset_pulse act=%b/%0d exp=0/0", p_valid, p_level); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single();
    do_reset();
    output_ready = 1'b1;
    input_data = 8'hA5;
    input_enable = 1'b1;
    for (int e = 0; e <= SYNC + 1; e++) begin
      @(negedge clock);
      tests_run++;
      if (o0_valid !== (e == SYNC)) begin tests_failed++; $display("FAIL single_valid edge=%0d act=%b exp=%b", e, o0_valid, (e == SYNC)); end
      if (e == SYNC) begin
        tests_run++; if (o0_data !== 8'hA5) begin tests_failed++; $display("FAIL single_data act=%h exp=a5", o0_data); end
        tests_run++; if (o0_level !== 3'd1) begin tests_failed++; $display("FAIL single_level1 act=%0d exp=1", o0_level); end
      end
    end
    tests_run++; if (o0_level !== 3'd0) begin tests_failed++; $display("FAIL single_level0 act=%0d exp=0", o0_level); end
    input_enable = 1'b0;
    output_ready = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) strobe(8'(i));
    tests_run++; if (o0_level !== 3'd4) begin tests_failed++; $display("FAIL fill_level act=%0d exp=4", o0_level); end
    tests_run++; if (o0_ovf !== 1'b1) begin tests_failed++; $display("FAIL fill_ovf act=%b exp=1", o0_ovf); end
    tests_run++; if (o0_drop !== 8'd1) begin tests_failed++; $display("FAIL fill_drop act=%0d exp=1", o0_drop); end
    output_ready = 1'b1;
    collect(0, 4);
    output_ready = 1'b0;
    tests_run++; if (got.size() != 4) begin tests_failed++; $display("FAIL fill_count act=%0d exp=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= got.size() || got[i] !== 8'(i + 1)) begin tests_failed++; $display("FAIL fill_order idx=%0d act=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, 8'(i + 1)); end
    end
    tests_run++; if (o0_level !== 3'd0 || o0_valid !== 1'b0) begin tests_failed++; $display("FAIL fill_empty act=%0d/%b exp=0/0", o0_level, o0_valid); end
    overflow_clear = 1'b1;
    @(negedge clock);
    overflow_clear = 1'b0;
    tests_run++; if (o0_ovf !== 1'b0 || o0_drop !== 8'd0) begin tests_failed++; $display("FAIL fill_clear act=%b/%0d exp=0/0", o0_ovf, o0_drop); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] w[5];
    do_reset();
    for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) strobe(w[i]);
    tests_run++; if (o0_level !== 3'd4) begin tests_failed++; $display("FAIL pp_fill act=%0d exp=4", o0_level); end
    input_data = w[4];
    input_enable = 1'b1;
    repeat (SYNC) @(negedge clock);
    tests_run++; if (o0_data !== w[0]) begin tests_failed++; $display("FAIL pp_head act=%h exp=%h", o0_data, w[0]); end
    output_ready = 1'b1;
    @(negedge clock);
    output_ready = 1'b0;
    tests_run++; if (o0_level !== 3'd4) begin tests_failed++; $display("FAIL pp_level act=%0d exp=4", o0_level); end
    tests_run++; if (o0_ovf !== 1'b0 || o0_drop !== 8'd0) begin tests_failed++; $display("FAIL pp_ovf act=%b/%0d exp=0/0", o0_ovf, o0_drop); end
    @(negedge clock);
    input_enable = 1'b0;
    repeat (2) @(negedge clock);
    output_ready = 1'b1;
    collect(0, 4);
    output_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= got.size() || got[i] !== w[i + 1]) begin tests_failed++; $display("FAIL pp_order idx=%0d act=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, w[i + 1]); end
    end
  endtask

  task automatic test_pulse();
    int adj;
    logic prev;
    do_reset();
    got.delete();
    adj = 0;
    prev = 1'b0;
    fork
      begin
        strobe(8'h10); strobe(8'h20); strobe(8'h30);
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clock);
          output_ready = 1'($urandom_range(0, 1));
          if (p_valid) begin
            got.push_back(p_data);
            if (prev) adj++;
          end
          prev = p_valid;
        end
      end
    join
    output_ready = 1'b0;
    tests_run++; if (got.size() != 3) begin tests_failed++; $display("FAIL pulse_count act=%0d exp=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (i >= got.size() || got[i] !== 8'((i + 1) * 16)) begin tests_failed++; $display("FAIL pulse_data idx=%0d act=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, 8'((i + 1) * 16)); end
    end
    tests_run++; if (adj != 0) begin tests_failed++; $display("FAIL pulse_width act=%0d exp=0", adj); end
    tests_run++; if (p_level !== 3'd0 || p_valid !== 1'b0) begin tests_failed++; $display("FAIL pulse_empty act=%0d/%b exp=0/0", p_level, p_valid); end
  endtask

  task automatic test_held_reset();
    logic [7:0] d, r3;
    do_reset();
    d = 8'($urandom);
    input_data = d;
    input_enable = 1'b1;
    repeat (20) @(negedge clock);
    tests_run++; if (o0_level !== 3'd1) begin tests_failed++; $display("FAIL held_level act=%0d exp=1", o0_level); end
    tests_run++; if (o0_data !== d) begin tests_failed++; $display("FAIL held_data act=%h exp=%h", o0_data, d); end
    input_enable = 1'b0;
    repeat (3) @(negedge clock);
    strobe(8'($urandom));
    strobe(8'($urandom));
    tests_run++; if (o0_level !== 3'd3) begin tests_failed++; $display("FAIL held_level3 act=%0d exp=3", o0_level); end
    r3 = 8'($urandom);
    input_data = r3;
    input_enable = 1'b1;
    reset = 1'b1;
    #1;
    tests_run++; if (o0_level !== 3'd0 || o0_valid !== 1'b0) begin tests_failed++; $display("FAIL held_async act=%0d/%b exp=0/0", o0_level, o0_valid); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (SYNC) @(negedge clock);
    tests_run++; if (o0_level !== 3'd0) begin tests_failed++; $display("FAIL held_early act=%0d exp=0", o0_level); end
    @(negedge clock);
    tests_run++; if (o0_level !== 3'd1 || o0_data !== r3) begin tests_failed++; $display("FAIL held_fresh act=%0d/%h exp=1/%h", o0_level, o0_data, r3); end
    repeat (6) @(negedge clock);
    tests_run++; if (o0_level !== 3'd1) begin tests_failed++; $display("FAIL held_once act=%0d exp=1", o0_level); end
    input_enable = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_wrap_sat();
    logic [7:0] q[$];
    logic [7:0] w;
    int k, drops;
    do_reset();
    drops = 0;
    for (int r = 0; r < 8; r++) begin
      k = $urandom_range(2, DEPTH + 2);
      q.delete();
      for (int i = 0; i < k; i++) begin
        w = 8'($urandom);
        if (q.size() < DEPTH) q.push_back(w);
        else drops++;
        strobe(w);
      end
      tests_run++; if (o0_level !== 3'(q.size())) begin tests_failed++; $display("FAIL wrap_level round=%0d act=%0d exp=%0d", r, o0_level, q.size()); end
      tests_run++; if (o0_drop !== 8'((drops > 255) ? 255 : drops) || o0_ovf !== (drops > 0)) begin tests_failed++; $display("FAIL wrap_drop round=%0d act=%0d/%b exp=%0d/%b", r, o0_drop, o0_ovf, drops, (drops > 0)); end
      output_ready = 1'b1;
      collect(0, q.size());
      output_ready = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
        tests_run++;
        if (i >= got.size() || got[i] !== q[i]) begin tests_failed++; $display("FAIL wrap_order round=%0d idx=%0d act=%h exp=%h", r, i, (i < got.size()) ? got[i] : 8'hxx, q[i]); end
      end
    end
    do_reset();
    for (int i = 0; i < DEPTH + 5; i++) strobe(8'($urandom));
    tests_run++; if (s_level !== 3'(DEPTH)) begin tests_failed++; $display("FAIL sat_level act=%0d exp=%0d", s_level, DEPTH); end
    tests_run++; if (s_drop !== 2'd3 || s_ovf !== 1'b1) begin tests_failed++; $display("FAIL sat_count act=%0d/%b exp=3/1", s_drop, s_ovf); end
    overflow_clear = 1'b1;
    @(negedge clock);
    overflow_clear = 1'b0;
    tests_run++; if (s_drop !== 2'd0 || s_ovf !== 1'b0) begin tests_failed++; $display("FAIL sat_clear act=%0d/%b exp=0/0", s_drop, s_ovf); end
    input_data = 8'($urandom);
    input_enable = 1'b1;
    repeat (SYNC) @(negedge clock);
    overflow_clear = 1'b1;
    @(negedge clock);
    overflow_clear = 1'b0;
    tests_run++; if (s_drop !== 2'd1 || s_ovf !== 1'b1) begin tests_failed++; $display("FAIL sat_clear_drop act=%0d/%b exp=1/1", s_drop, s_ovf); end
    @(negedge clock);
    input_enable = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    input_data = 8'h00;
    input_enable = 1'b0;
    output_ready = 1'b0;
    overflow_clear = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_pulse();
    test_held_reset();
    test_wrap_sat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
